// File: rtl/x_uart_rx.sv
// 8-bit asynchronous serial receiver with a single-entry valid/accept output register.
// Define X_UART_RX_PARITY_EN to add an even-parity bit between D7 and STOP.
module x_uart_rx #(
    parameter int p_clk_hz = 12000000,
    parameter int p_baud   = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_accept,
    output logic       o_ferr,
    output logic       o_overrun,
    output logic       o_perr,
    output logic [3:0] o_state
);

    localparam int unsigned p_timer_top  = p_clk_hz / p_baud;
    localparam int unsigned p_timer_half = p_timer_top / 2;
    localparam int unsigned lp_tw        = $clog2(p_timer_top + 1);
    localparam logic [lp_tw-1:0] lp_top  = lp_tw'(p_timer_top);
    localparam logic [lp_tw-1:0] lp_half = lp_tw'(p_timer_half);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_D0    = 4'd2,
        S_D1    = 4'd3,
        S_D2    = 4'd4,
        S_D3    = 4'd5,
        S_D4    = 4'd6,
        S_D5    = 4'd7,
        S_D6    = 4'd8,
        S_D7    = 4'd9,
`ifdef X_UART_RX_PARITY_EN
        S_PAR   = 4'd10,
`endif
        S_STOP  = 4'd11
    } state_t;

    state_t            state_q, state_d;
    logic [lp_tw-1:0]  timer_q, timer_d;
    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              overrun_q, overrun_d;
    logic              stop_sample;
    logic [2:0]        bit_idx;
`ifdef X_UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    // State register: synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef X_UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef X_UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Next-state logic: bit timer, shift register and frame sequencing.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
        bit_idx     = 3'(state_q - S_D0);
`ifdef X_UART_RX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (rx_prev_q && !rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (timer_q == lp_half) begin
                    timer_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_D0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (timer_q == lp_top) begin
                    timer_d = '0;
                    if (state_q == S_STOP) begin
                        stop_sample = 1'b1;
                        state_d     = S_IDLE;
`ifdef X_UART_RX_PARITY_EN
                    end else if (state_q == S_PAR) begin
                        par_d   = rx_s_q;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d[bit_idx] = rx_s_q;
                        if (state_q == S_D7) begin
`ifdef X_UART_RX_PARITY_EN
                            state_d = S_PAR;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            state_d = state_t'(state_q + 4'd1);
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
    end

    // Output register: a completed frame always lands, even over an unconsumed byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q & ~i_accept;
        ferr_d    = 1'b0;
        overrun_d = 1'b0;
`ifdef X_UART_RX_PARITY_EN
        perr_d    = stop_sample & (^{shift_q, par_q});
`endif
        if (stop_sample) begin
            if (rx_s_q) begin
                data_d    = shift_q;
                valid_d   = 1'b1;
                overrun_d = valid_q & ~i_accept;
            end else begin
                ferr_d = 1'b1;
            end
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_ferr    = ferr_q;
    assign o_overrun = overrun_q;
    assign o_state   = state_q;
`ifdef X_UART_RX_PARITY_EN
    assign o_perr    = perr_q;
`else
    assign o_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_x_uart_rx.sv
// Bench for x_uart_rx: frame-level model predicting output register contents and pulses.
// Build with X_UART_RX_PARITY_EN to exercise the parity frame format.
module tb_x_uart_rx;

  localparam int TOP  = 12000000 / 115200;
  localparam int HALF = TOP / 2;
  localparam int BIT  = TOP + 1;
`ifdef X_UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Start edge -> 2 sync flops + edge register, half-bit start check, then the remaining bit periods.
  localparam int LAT = 3 + (HALF + 1) + BIT * (FRAME_BITS - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       accept = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, overrun, perr;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         ok;
    bit         pe;
  } ev_t;
  ev_t pend[$];

  logic [7:0] exp_q[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

  x_uart_rx dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx),
    .o_data(data),
    .o_valid(valid),
    .i_accept(accept),
    .o_ferr(ferr),
    .o_overrun(overrun),
    .o_perr(perr),
    .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // frame-level model: a frame finishing at its computed cycle updates the output register
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      pend.delete();
      exp_q.delete();
    end else begin
      logic nv;
      ev_t  e;
      nv     = m_valid & ~accept;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      m_perr = 1'b0;
      if (m_valid && accept && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend.size() > 0 && pend[0].at == cyc + 1) begin
        e = pend.pop_front();
        if (e.ok) begin
          m_ovr  = m_valid & ~accept;
          if (m_ovr && exp_q.size() > 0) void'(exp_q.pop_front());
          m_data = e.d;
          exp_q.push_back(e.d);
          nv     = 1'b1;
        end else begin
          m_ferr = 1'b1;
        end
        m_perr = e.pe;
      end
      m_valid = nv;
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("valid", 32'(valid), 32'(m_valid));
    chk("data", 32'(data), 32'(m_data));
    chk("ferr", 32'(ferr), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("perr", 32'(perr), 32'(m_perr));
    if (valid === 1'b1 && exp_q.size() > 0) chk("sb_head", 32'(data), 32'(exp_q[0]));
    if (ferr === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (perr === 1'b1) perr_cnt++;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(BIT);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
    ev_t  e;
    logic pbit;
    pbit = (^d) ^ par_flip;
    e.at = cyc + LAT;
    e.d  = d;
    e.ok = stop_b;
`ifdef X_UART_RX_PARITY_EN
    e.pe = ^{d, pbit};
`else
    e.pe = 1'b0;
`endif
    pend.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef X_UART_RX_PARITY_EN
    drive_bit(pbit);
`endif
    drive_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic do_accept();
    accept = 1'b1;
    tick(1);
    accept = 1'b0;
  endtask

  initial begin
    int f0, o0, p0, k;
    tick(3);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    rst = 1'b0;
    tick(5);

    // 0xA5, held until accepted
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    send(8'hA5, 1'b1, 1'b0);
    tick(60);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_valid", 32'(valid), 32'h1);
    do_accept();
    chk("a5_drop", 32'(valid), 32'h0);
    chk("a5_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0), 32'h0);
    accept = 1'b1;
    tick(3);
    accept = 1'b0;

    // short low glitch rejected at half bit
    f0 = ferr_cnt;
    rx = 1'b0;
    tick(20);
    chk("glitch_start", 32'(state), 32'h1);
    rx = 1'b1;
    tick(40);
    chk("glitch_idle", 32'(state), 32'h0);
    chk("glitch_valid", 32'(valid), 32'h0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);

    // framing error on 0x3C
    f0 = ferr_cnt;
    send(8'h3C, 1'b0, 1'b0);
    tick(200);
    chk("ferr_once", 32'(ferr_cnt - f0), 32'h1);
    chk("ferr_valid", 32'(valid), 32'h0);

    // back-to-back overrun
    o0 = ovr_cnt;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    tick(20);
    chk("ovr_data", 32'(data), 32'h22);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_once", 32'(ovr_cnt - o0), 32'h1);
    do_accept();

    // completion in the same cycle as accept: no overrun
    send(8'h66, 1'b1, 1'b0);
    o0 = ovr_cnt;
    k = cyc;
    fork
      send(8'h99, 1'b1, 1'b0);
      begin
        tick(LAT - 1);
        do_accept();
      end
    join
    tick(5);
    chk("same_data", 32'(data), 32'h99);
    chk("same_valid", 32'(valid), 32'h1);
    chk("same_ovr", 32'(ovr_cnt - o0), 32'h0);
    chk("same_lat", 32'(cyc - k > LAT), 32'h1);
    do_accept();

    // reset in the middle of D4 of 0xFF
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    rx = 1'b0;
    tick(BIT);
    rx = 1'b1;
    tick(530 - BIT);
    chk("mid_d4", 32'(state), 32'h6);
    rst = 1'b1;
    tick(3);
    chk("mid_rst_state", 32'(state), 32'h0);
    chk("mid_rst_data", 32'(data), 32'h00);
    rst = 1'b0;
    tick(600);
    send(8'h5A, 1'b1, 1'b0);
    tick(20);
    chk("post_rst_data", 32'(data), 32'h5A);
    chk("post_rst_valid", 32'(valid), 32'h1);
    chk("post_rst_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0 + perr_cnt - p0), 32'h0);
    do_accept();

`ifdef X_UART_RX_PARITY_EN
    // 0x07 has three ones, so parity bit 0 is a mismatch
    p0 = perr_cnt;
    send(8'h07, 1'b1, 1'b1);
    tick(20);
    chk("par_bad_data", 32'(data), 32'h07);
    chk("par_bad_valid", 32'(valid), 32'h1);
    chk("par_bad_once", 32'(perr_cnt - p0), 32'h1);
    do_accept();
    p0 = perr_cnt;
    send(8'h07, 1'b1, 1'b0);
    tick(20);
    chk("par_ok_none", 32'(perr_cnt - p0), 32'h0);
    do_accept();
`else
    chk("perr_never", 32'(perr_cnt), 32'h0);
`endif

    tick(10);
    chk("pend_empty", 32'(pend.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
